// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose: run-control state enum, default widths, first fetch address and
//          cycle-counter width used by fetch_unit and its counter.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } fetchState_t;

   localparam int DEF_PW         = 10;
   localparam int DEF_IW         = 9;
   localparam int DEF_START_ADDR = 0;
   localparam int CT_W           = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
// Purpose: counts enabled cycles, sticks at all-ones, Clr wins over En.
// Ports:
//   Clk   - clock
//   Reset - asynchronous active-low reset, clears Count
//   Clr   - synchronous clear
//   En    - count enable
//   Count - current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Clr,
   input  logic         En,
   output logic [W-1:0] Count
);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Count <= '0;
      end else if (Clr) begin
         Count <= '0;
      end else if (En && (Count != {W{1'b1}})) begin
         Count <= Count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with run control, branch and halt
// Purpose: owns the PC, the Start/Ack handshake and the registered instruction.
// Ports:
//   Clk, Reset          - clock, asynchronous active-low reset
//   Start               - run request; program begins when it falls
//   Stall               - freezes the stage for one cycle
//   BranchEn, Target    - taken branch for the instruction in Inst
//   Halt                - instruction in Inst ends the program
//   InstData / InstAddr - combinational instruction ROM data / address
//   Inst, InstValid     - registered instruction and its valid bit
//   PgmCtr              - address Inst was fetched from
//   Ack                 - program done
//   CycleCt             - saturating count of cycles spent in RUN
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PW         = DEF_PW,
   parameter int IW         = DEF_IW,
   parameter int START_ADDR = DEF_START_ADDR
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic            Stall,
   input  logic            BranchEn,
   input  logic [PW-1:0]   Target,
   input  logic            Halt,
   input  logic [IW-1:0]   InstData,
   output logic [PW-1:0]   InstAddr,
   output logic [IW-1:0]   Inst,
   output logic            InstValid,
   output logic [PW-1:0]   PgmCtr,
   output logic            Ack,
   output logic [CT_W-1:0] CycleCt
);

   localparam logic [PW-1:0] START_PC = PW'(START_ADDR);

   fetchState_t   state, stateNxt;
   logic [PW-1:0] pc, pcNxt;
   logic [IW-1:0] instNxt;
   logic [PW-1:0] pgmCtrNxt;
   logic          validNxt;
   logic          ackNxt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         pc        <= START_PC;
         Inst      <= '0;
         PgmCtr    <= '0;
         InstValid <= 1'b0;
         Ack       <= 1'b0;
      end else begin
         state     <= stateNxt;
         pc        <= pcNxt;
         Inst      <= instNxt;
         PgmCtr    <= pgmCtrNxt;
         InstValid <= validNxt;
         Ack       <= ackNxt;
      end
   end

   always_comb begin
      stateNxt  = state;
      pcNxt     = pc;
      instNxt   = Inst;
      pgmCtrNxt = PgmCtr;
      validNxt  = InstValid;
      ackNxt    = Ack;

      // Start overrides everything, including a program in flight.
      if (Start) begin
         stateNxt = ARMED;
         pcNxt    = START_PC;
         validNxt = 1'b0;
         ackNxt   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               validNxt = 1'b0;
            end
            ARMED: begin
               stateNxt  = RUN;
               instNxt   = InstData;
               pgmCtrNxt = pc;
               pcNxt     = pc + 1'b1;
               validNxt  = 1'b1;
            end
            RUN: begin
               // Halt/branch only count against a live instruction; a bubble ignores them.
               if (!Stall) begin
                  if (Halt && InstValid) begin
                     stateNxt = DONE;
                     ackNxt   = 1'b1;
                     validNxt = 1'b0;
                  end else if (BranchEn && InstValid) begin
                     pcNxt    = Target;
                     validNxt = 1'b0;
                  end else begin
                     instNxt   = InstData;
                     pgmCtrNxt = pc;
                     pcNxt     = pc + 1'b1;
                     validNxt  = 1'b1;
                  end
               end
            end
            DONE: begin
               stateNxt = DONE;
            end
            default: begin
               stateNxt = IDLE;
            end
         endcase
      end
   end

   assign InstAddr = pc;

   sat_counter #(
      .W(CT_W)
   ) uCycleCt (
      .Clk   (Clk),
      .Reset (Reset),
      .Clr   (Start),
      .En    (state == RUN),
      .Count (CycleCt)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam int PW    = 10;
   localparam int IW    = 9;
   localparam int START = 0;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          Stall;
   logic          BranchEn;
   logic [PW-1:0] Target;
   logic          Halt;
   logic [IW-1:0] InstData;
   logic [PW-1:0] InstAddr;
   logic [IW-1:0] Inst;
   logic          InstValid;
   logic [PW-1:0] PgmCtr;
   logic          Ack;
   logic [15:0]   CycleCt;

   logic [IW-1:0] rom [0:(1<<PW)-1];

   int nChecks = 0;
   int nPass   = 0;

   fetch_unit #(
      .PW(PW),
      .IW(IW),
      .START_ADDR(START)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Stall     (Stall),
      .BranchEn  (BranchEn),
      .Target    (Target),
      .Halt      (Halt),
      .InstData  (InstData),
      .InstAddr  (InstAddr),
      .Inst      (Inst),
      .InstValid (InstValid),
      .PgmCtr    (PgmCtr),
      .Ack       (Ack),
      .CycleCt   (CycleCt)
   );

   always #5 Clk = ~Clk;

   assign InstData = rom[InstAddr];

   // Reference model: program-level view of the fetch stage.
   int  mPc     = START;
   int  mInst   = 0;
   int  mPgm    = 0;
   bit  mValid  = 0;
   bit  mAck    = 0;
   int  mCt     = 0;
   bit  armed   = 0;
   bit  running = 0;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         mPc = START; mInst = 0; mPgm = 0; mValid = 0; mAck = 0; mCt = 0;
         armed = 0; running = 0;
      end else if (Start) begin
         armed = 1; running = 0;
         mPc = START; mValid = 0; mAck = 0; mCt = 0;
      end else if (armed) begin
         armed = 0; running = 1;
         mInst = rom[mPc]; mPgm = mPc; mPc = (mPc + 1) % (1 << PW); mValid = 1;
      end else if (running) begin
         if (mCt < 65535) mCt = mCt + 1;
         if (Stall) begin
            // frozen
         end else if (Halt && mValid) begin
            running = 0; mAck = 1; mValid = 0;
         end else if (BranchEn && mValid) begin
            mPc = Target; mValid = 0;
         end else begin
            mInst = rom[mPc]; mPgm = mPc; mPc = (mPc + 1) % (1 << PW); mValid = 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         nPass++;
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      check("m_InstAddr",  32'(InstAddr),  32'(mPc));
      check("m_Inst",      32'(Inst),      32'(mInst));
      check("m_PgmCtr",    32'(PgmCtr),    32'(mPgm));
      check("m_InstValid", 32'(InstValid), 32'(mValid));
      check("m_Ack",       32'(Ack),       32'(mAck));
      check("m_CycleCt",   32'(CycleCt),   32'(mCt));
   end

   task automatic tick;
      @(posedge Clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0; Halt = 1'b0; Target = '0;
      for (int i = 0; i < (1 << PW); i++) rom[i] = IW'((i * 37 + 5) & 9'h1FF);
      rom[0] = 9'h101; rom[1] = 9'h0A2; rom[2] = 9'h0C3; rom[3] = 9'h1FF;
      rom[10'h040] = 9'h155;
      rom[10'h080] = 9'h0AA;

      repeat (2) tick;
      Reset = 1'b1;
      check("rst_InstValid", 32'(InstValid), 32'd0);
      check("rst_Ack",       32'(Ack),       32'd0);
      check("rst_InstAddr",  32'(InstAddr),  32'd0);
      check("rst_CycleCt",   32'(CycleCt),   32'd0);

      // Sequential fetch of the first four words.
      Start = 1'b1; repeat (3) tick; Start = 1'b0;
      tick; check("seq0_Inst", 32'(Inst), 32'h101); check("seq0_Pgm", 32'(PgmCtr), 32'd0);
            check("seq0_Valid", 32'(InstValid), 32'd1); check("seq0_Addr", 32'(InstAddr), 32'd1);
      tick; check("seq1_Inst", 32'(Inst), 32'h0A2); check("seq1_Pgm", 32'(PgmCtr), 32'd1);
      tick; check("seq2_Inst", 32'(Inst), 32'h0C3); check("seq2_Pgm", 32'(PgmCtr), 32'd2);
      tick; check("seq3_Inst", 32'(Inst), 32'h1FF); check("seq3_Pgm", 32'(PgmCtr), 32'd3);

      // Branch from PgmCtr 2 to 0x040.
      Start = 1'b1; tick; Start = 1'b0;
      repeat (3) tick;
      check("br_pre_Pgm", 32'(PgmCtr), 32'h002);
      BranchEn = 1'b1; Target = 10'h040; tick;
      check("br_bubble_Valid", 32'(InstValid), 32'd0);
      check("br_bubble_Addr",  32'(InstAddr),  32'h040);
      BranchEn = 1'b0; tick;
      check("br_land_Inst", 32'(Inst),    32'h155);
      check("br_land_Pgm",  32'(PgmCtr),  32'h040);
      check("br_land_Ct",   32'(CycleCt), 32'd4);

      // Two stalled cycles with a branch held pending.
      Stall = 1'b1; BranchEn = 1'b1; Target = 10'h080;
      repeat (2) tick;
      check("stall_Pgm",  32'(PgmCtr),   32'h040);
      check("stall_Addr", 32'(InstAddr), 32'h041);
      check("stall_Inst", 32'(Inst),     32'h155);
      check("stall_Ct",   32'(CycleCt),  32'd6);
      Stall = 1'b0; tick;
      check("stall_br_Valid", 32'(InstValid), 32'd0);
      check("stall_br_Addr",  32'(InstAddr),  32'h080);
      check("stall_br_Ct",    32'(CycleCt),   32'd7);
      BranchEn = 1'b0; tick;
      check("stall_land_Inst", 32'(Inst),   32'h0AA);
      check("stall_land_Pgm",  32'(PgmCtr), 32'h080);

      // Halt at PgmCtr 0x010 after 17 RUN cycles.
      Start = 1'b1; tick; Start = 1'b0; tick;
      repeat (16) tick;
      check("halt_pre_Pgm", 32'(PgmCtr),  32'h010);
      check("halt_pre_Ct",  32'(CycleCt), 32'd16);
      Halt = 1'b1; tick; Halt = 1'b0;
      check("halt_Ack",   32'(Ack),       32'd1);
      check("halt_Valid", 32'(InstValid), 32'd0);
      check("halt_Ct",    32'(CycleCt),   32'd17);
      repeat (3) tick;
      check("done_Ack",  32'(Ack),      32'd1);
      check("done_Ct",   32'(CycleCt),  32'd17);
      check("done_Addr", 32'(InstAddr), 32'h011);
      Start = 1'b1; tick;
      check("restart_Ack", 32'(Ack),     32'd0);
      check("restart_Ct",  32'(CycleCt), 32'd0);
      Start = 1'b0;

      // Wrap from 0x3FF to 0x000; Halt in the bubble is ignored.
      tick;
      BranchEn = 1'b1; Target = 10'h3FE; tick;
      BranchEn = 1'b0; Halt = 1'b1; tick;
      check("bubble_halt_Ack",  32'(Ack),       32'd0);
      check("wrap0_Pgm",        32'(PgmCtr),    32'h3FE);
      check("wrap0_Valid",      32'(InstValid), 32'd1);
      check("wrap0_Addr",       32'(InstAddr),  32'h3FF);
      Halt = 1'b0; tick;
      check("wrap1_Pgm",  32'(PgmCtr),   32'h3FF);
      check("wrap1_Addr", 32'(InstAddr), 32'h000);
      tick;
      check("wrap2_Pgm",  32'(PgmCtr),   32'h000);
      check("wrap2_Inst", 32'(Inst),     32'h101);
      check("wrap2_Ack",  32'(Ack),      32'd0);

      // Asynchronous reset mid-RUN at PC 0x05.
      Start = 1'b1; tick; Start = 1'b0; tick;
      repeat (4) tick;
      check("arst_pre_Addr", 32'(InstAddr), 32'h005);
      Reset = 1'b0; #1;
      check("arst_Valid", 32'(InstValid), 32'd0);
      check("arst_Ack",   32'(Ack),       32'd0);
      check("arst_Addr",  32'(InstAddr),  32'h000);
      check("arst_Ct",    32'(CycleCt),   32'd0);
      check("arst_Pgm",   32'(PgmCtr),    32'd0);
      repeat (2) tick;
      Reset = 1'b1; repeat (2) tick;
      check("idle_Valid", 32'(InstValid), 32'd0);
      check("idle_Ct",    32'(CycleCt),   32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
